// File: rtl/ireg_skew_feeder.sv
// ireg_skew_feeder: re-times accepted ROWS-wide vectors into a diagonal wavefront for the array rows.
// Build option IREG_SKEW_FEEDER_ZERO_BUBBLE_EN zeroes a row's data whenever its enable is low.
module ireg_skew_feeder #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic [ROWS*WIDTH-1:0] s_data,
  output logic [ROWS*WIDTH-1:0] o_data,
  output logic [ROWS-1:0]       o_en,
  output logic [ROWS-1:0]       o_clr,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      beat_cnt
);

  // state  | meaning
  // IDLE   | no job open; first accepted beat starts one
  // STREAM | job open; accepts beats, s_valid low injects bubbles
  // FLUSH  | last beat taken; ROWS cycles draining the skew pipes
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  localparam int FCW = $clog2(ROWS);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(ROWS - 1);

  state_t         state;
  logic [FCW-1:0] flush_cnt;
  logic           accept;

  assign s_ready = rst_n && !clr && (state == IDLE || state == STREAM);
  assign accept  = s_valid && s_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
      done      <= 1'b0;
      beat_cnt  <= '0;
      o_clr     <= '0;
    end else if (clr) begin
      state     <= IDLE;
      flush_cnt <= '0;
      done      <= 1'b0;
      beat_cnt  <= '0;
      o_clr     <= '1;
    end else begin
      o_clr <= '0;
      done  <= 1'b0;
      if (accept) begin
        if (state == IDLE) begin
          beat_cnt <= CNT_W'(1);
        end else if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      case (state)
        IDLE, STREAM: begin
          if (accept) begin
            if (s_last) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end else begin
              state <= STREAM;
            end
          end
        end
        FLUSH: begin
          // terminal count reached after exactly ROWS cycles in FLUSH
          if (flush_cnt == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0]       v;
    logic [WIDTH-1:0] d [r+1];

    // stage 0 data only loads on acceptance, so bubbles carry the previous beat's data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= '0;
        for (int k = 0; k <= r; k++) d[k] <= '0;
      end else if (clr) begin
        v <= '0;
        for (int k = 0; k <= r; k++) d[k] <= '0;
      end else begin
        v[0] <= accept;
        if (accept) d[0] <= s_data[r*WIDTH +: WIDTH];
        for (int k = 1; k <= r; k++) begin
          v[k] <= v[k-1];
          d[k] <= d[k-1];
        end
      end
    end

    assign o_en[r] = v[r];
`ifdef IREG_SKEW_FEEDER_ZERO_BUBBLE_EN
    assign o_data[r*WIDTH +: WIDTH] = v[r] ? d[r] : '0;
`else
    assign o_data[r*WIDTH +: WIDTH] = d[r];
`endif
  end

endmodule
